// File: rtl/register_bank_pkg.sv
// Shared types and default geometry for the general-purpose register bank.
package register_bank_pkg;

  // Controller phases: clearing the storage after reset, then normal operation.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rb_state_e;

  localparam int RB_DATA_WIDTH = 32;
  localparam int RB_ADDR_WIDTH = 5;
  localparam int RB_READ_PORTS = 2;

endpackage

// File: rtl/register_bank_if.sv
// Decode/writeback-side bundle of the register bank: read ports, write port,
// busy marking and the initialisation status flag.
interface register_bank_if
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int READ_PORTS = RB_READ_PORTS
) ();

  logic [READ_PORTS-1:0]            rd_en;
  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]            rd_busy;
  logic                             wr_en;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             busy_set;
  logic [ADDR_WIDTH-1:0]            busy_addr;
  logic                             init_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    input  rd_data, rd_busy, init_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    output rd_data, rd_busy, init_done
  );

endinterface

// File: rtl/register_bank_busy_table.sv
// Busy scoreboard: one pending bit per register. Set beats clear on the same
// address, entry 0 can never be pending, and each query port sees the bit as
// it will be after this edge so a same-cycle set/clear is already reflected.
module register_bank_busy_table
  import register_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int READ_PORTS = RB_READ_PORTS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             set_i,
  input  logic [ADDR_WIDTH-1:0]            set_addr_i,
  input  logic                             clr_i,
  input  logic [ADDR_WIDTH-1:0]            clr_addr_i,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] query_addr_i,
  output logic [READ_PORTS-1:0]            query_next_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next-state scoreboard: clear first so a simultaneous set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end else begin
      busy_d[clr_addr_i] = busy_q[clr_addr_i];
    end
    if (set_i) begin
      busy_d[set_addr_i] = 1'b1;
    end else begin
      busy_d[set_addr_i] = busy_d[set_addr_i];
    end
    busy_d[0] = 1'b0;
  end

  // Per-port lookup of the post-edge busy bit.
  always_comb begin
    query_next_o = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      query_next_o[p] = busy_d[query_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Scoreboard state, all clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/register_bank.sv
// Parametrised multi-read-port register bank with registered reads, optional
// write-to-read bypass, hardwired zero register, post-reset clearing sweep and
// busy scoreboard for outstanding multi-cycle destinations.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int READ_PORTS = RB_READ_PORTS,
  parameter bit BYPASS     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  register_bank_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  rb_state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]            cnt_q, cnt_d;
  logic                             init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0]            mem_q [DEPTH];
  logic                             mem_we_s;
  logic [ADDR_WIDTH-1:0]            mem_waddr_s;
  logic [DATA_WIDTH-1:0]            mem_wdata_s;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [READ_PORTS-1:0]            rd_busy_q, rd_busy_d;
  logic [READ_PORTS-1:0]            busy_next_s;
  logic [ADDR_WIDTH-1:0]            rd_addr_s [READ_PORTS];
  logic                             run_s;

  assign run_s = (state_q == ST_RUN);

  for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_addr
    assign rd_addr_s[gp] = bus.rd_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Clearing sweep walks every entry once, then the bank stays in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // Single storage write port: zero-fill during the sweep, writeback after;
  // writes to entry 0 are dropped so it keeps the value cleared by the sweep.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    if (run_s) begin
      if (bus.wr_en && (bus.wr_addr != '0)) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = bus.wr_addr;
        mem_wdata_s = bus.wr_data;
      end else begin
        mem_we_s    = 1'b0;
      end
    end else begin
      mem_we_s    = 1'b1;
      mem_waddr_s = cnt_q;
      mem_wdata_s = '0;
    end
  end

  // Storage array; a reset edge never lands a write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  register_bank_busy_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_PORTS (READ_PORTS)
  ) u_busy_table (
    .clk          (clk),
    .rst          (rst),
    .set_i        (run_s & bus.busy_set),
    .set_addr_i   (bus.busy_addr),
    .clr_i        (run_s & bus.wr_en),
    .clr_addr_i   (bus.wr_addr),
    .query_addr_i (bus.rd_addr),
    .query_next_o (busy_next_s)
  );

  // Read ports: load on strobe, hold otherwise; zero during the sweep and for r0.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (bus.rd_en[p]) begin
        if (!run_s || (rd_addr_s[p] == '0)) begin
          rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = '0;
          rd_busy_d[p] = 1'b0;
        end else if (BYPASS && bus.wr_en && (bus.wr_addr == rd_addr_s[p])) begin
          rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
          rd_busy_d[p] = busy_next_s[p];
        end else begin
          rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr_s[p]];
          rd_busy_d[p] = busy_next_s[p];
        end
      end else begin
        rd_busy_d[p] = rd_busy_q[p];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_data_q   <= '0;
      rd_busy_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_data_q   <= rd_data_d;
      rd_busy_q   <= rd_busy_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_busy   = rd_busy_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: two 32x32 banks (bypass on/off) driven identically and
// compared against an array-based reference model, plus a small 3-port bank.
module tb_register_bank;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy_set;
  logic [4:0]  busy_addr;

  logic [2:0]  c_rd_en;
  logic [8:0]  c_rd_addr;
  logic        c_wr_en;
  logic [2:0]  c_wr_addr;
  logic [15:0] c_wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] mem_m [32];
  bit          busy_m [32];
  int          run_cnt;
  logic [31:0] exp_da [2];
  logic [31:0] exp_db [2];
  bit          exp_bu [2];

  register_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2)) if_a ();
  register_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2)) if_b ();
  register_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(3)) if_c ();

  assign if_a.rd_en = rd_en;       assign if_b.rd_en = rd_en;
  assign if_a.rd_addr = rd_addr;   assign if_b.rd_addr = rd_addr;
  assign if_a.wr_en = wr_en;       assign if_b.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr;   assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data;   assign if_b.wr_data = wr_data;
  assign if_a.busy_set = busy_set; assign if_b.busy_set = busy_set;
  assign if_a.busy_addr = busy_addr; assign if_b.busy_addr = busy_addr;

  assign if_c.rd_en = c_rd_en;
  assign if_c.rd_addr = c_rd_addr;
  assign if_c.wr_en = c_wr_en;
  assign if_c.wr_addr = c_wr_addr;
  assign if_c.wr_data = c_wr_data;
  assign if_c.busy_set = 1'b0;
  assign if_c.busy_addr = 3'd0;

  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(3), .BYPASS(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 2'b00; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0;
    wr_data = 32'd0; busy_set = 1'b0; busy_addr = 5'd0;
    c_rd_en = 3'b000; c_rd_addr = 9'd0; c_wr_en = 1'b0; c_wr_addr = 3'd0; c_wr_data = 16'd0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cycle();
    bit          nb [32];
    logic [4:0]  ad;
    @(posedge clk);
    if (rst) begin
      run_cnt = 0;
      for (int i = 0; i < 32; i++) begin mem_m[i] = 32'd0; busy_m[i] = 1'b0; end
      for (int p = 0; p < 2; p++) begin exp_da[p] = 32'd0; exp_db[p] = 32'd0; exp_bu[p] = 1'b0; end
    end else if (run_cnt < 32) begin
      for (int p = 0; p < 2; p++)
        if (rd_en[p]) begin exp_da[p] = 32'd0; exp_db[p] = 32'd0; exp_bu[p] = 1'b0; end
      run_cnt++;
    end else begin
      nb = busy_m;
      if (wr_en && wr_addr != 5'd0) nb[wr_addr] = 1'b0;
      if (busy_set && busy_addr != 5'd0) nb[busy_addr] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          ad = rd_addr[p*5 +: 5];
          if (ad == 5'd0) begin
            exp_da[p] = 32'd0; exp_db[p] = 32'd0; exp_bu[p] = 1'b0;
          end else begin
            exp_da[p] = (wr_en && wr_addr == ad) ? wr_data : mem_m[ad];
            exp_db[p] = mem_m[ad];
            exp_bu[p] = nb[ad];
          end
        end
      end
      if (wr_en && wr_addr != 5'd0) mem_m[wr_addr] = wr_data;
      busy_m = nb;
    end
    #1;
    check_eq("init_done_a", 64'(if_a.init_done), 64'(run_cnt >= 32));
    check_eq("init_done_b", 64'(if_b.init_done), 64'(run_cnt >= 32));
    check_eq("init_done_c", 64'(if_c.init_done), 64'(run_cnt >= 8));
    for (int p = 0; p < 2; p++) begin
      check_eq($sformatf("rd_data_a[%0d]", p), 64'(if_a.rd_data[p*32 +: 32]), 64'(exp_da[p]));
      check_eq($sformatf("rd_data_b[%0d]", p), 64'(if_b.rd_data[p*32 +: 32]), 64'(exp_db[p]));
      check_eq($sformatf("rd_busy_a[%0d]", p), 64'(if_a.rd_busy[p]), 64'(exp_bu[p]));
      check_eq($sformatf("rd_busy_b[%0d]", p), 64'(if_b.rd_busy[p]), 64'(exp_bu[p]));
    end
  endtask

  initial begin
    run_cnt = 0;
    idle();
    rst = 1'b1;
    cycle();
    check_eq("reset_init_done", 64'(if_a.init_done), 64'd0);
    check_eq("reset_rd_data", 64'(if_a.rd_data), 64'd0);

    // sweep: reads during the clearing phase, init_done rises after edge 32
    idle();
    for (int k = 1; k <= 32; k++) begin
      rd_en = 2'b11; rd_addr = {rand_addr(), rand_addr()};
      cycle();
      if (k == 31) check_eq("init_done_edge31", 64'(if_a.init_done), 64'd0);
    end
    check_eq("init_done_edge32", 64'(if_a.init_done), 64'd1);

    // every register reads back cleared
    for (int a = 1; a < 32; a++) begin
      idle(); rd_en = 2'b11; rd_addr = {5'(a), 5'(a)};
      cycle();
    end

    // same-edge write/read of r5
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cycle();
    check_eq("bypass_on_r5", 64'(if_a.rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    check_eq("bypass_off_r5", 64'(if_b.rd_data[31:0]), 64'd0);
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cycle();
    check_eq("bypass_off_reread", 64'(if_b.rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);

    // hardwired zero register
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cycle();
    check_eq("r0_write_dropped", 64'(if_a.rd_data), 64'd0);
    idle(); busy_set = 1'b1; busy_addr = 5'd0; rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cycle();
    check_eq("r0_never_busy", 64'(if_a.rd_busy), 64'd0);

    // busy scoreboard on r7
    idle(); busy_set = 1'b1; busy_addr = 5'd7;
    cycle();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    cycle();
    check_eq("r7_busy_set", 64'(if_a.rd_busy[0]), 64'd1);
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12; rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    cycle();
    check_eq("r7_write_data", 64'(if_a.rd_data[31:0]), 64'h12);
    check_eq("r7_write_clears", 64'(if_a.rd_busy[0]), 64'd0);
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h34; busy_set = 1'b1; busy_addr = 5'd7;
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    cycle();
    check_eq("r7_set_wins", 64'(if_a.rd_busy), 64'd3);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 249) == 0);
      rd_en = 2'($urandom); rd_addr = {rand_addr(), rand_addr()};
      wr_en = ($urandom_range(0, 1) == 1); wr_addr = rand_addr(); wr_data = $urandom;
      busy_set = ($urandom_range(0, 3) == 0); busy_addr = rand_addr();
      cycle();
    end
    idle();
    while (run_cnt < 32) cycle();

    // reset in RUN after writing r3
    idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
    cycle();
    idle(); rst = 1'b1;
    cycle();
    check_eq("midrun_init_done_drop", 64'(if_a.init_done), 64'd0);
    idle();
    for (int k = 0; k < 32; k++) cycle();
    idle(); rd_en = 2'b11; rd_addr = {5'd7, 5'd3};
    cycle();
    check_eq("midrun_r3_cleared", 64'(if_a.rd_data[31:0]), 64'd0);
    check_eq("midrun_r7_not_busy", 64'(if_a.rd_busy[1]), 64'd0);
    for (int a = 1; a < 32; a++) begin
      idle(); rd_en = 2'b11; rd_addr = {5'(a), 5'(a)};
      cycle();
    end

    // 3-port, 16-bit, 8-entry bank
    idle(); c_wr_en = 1'b1; c_wr_addr = 3'd2; c_wr_data = 16'hBEEF;
    cycle();
    idle(); c_rd_en = 3'b111; c_rd_addr = {3'd2, 3'd2, 3'd2};
    cycle();
    for (int p = 0; p < 3; p++)
      check_eq($sformatf("c_port%0d_r2", p), 64'(if_c.rd_data[p*16 +: 16]), 64'hBEEF);
    idle(); c_wr_en = 1'b1; c_wr_addr = 3'd0; c_wr_data = 16'h1234;
    c_rd_en = 3'b111; c_rd_addr = {3'd0, 3'd2, 3'd0};
    cycle();
    check_eq("c_mixed_r0_r2", 64'(if_c.rd_data), 64'h0000_BEEF_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
